seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle logarithmic shifter for the processor's shift path (SLL/SRL/SRA, optional rotate).
- Sits directly upstream of the 1-bit shift stage and drives its operand. It applies one power-of-two sub-shift per cycle, LSB of shamt first.
- Result feeds the execute-stage writeback mux under a start/ready handshake matching the multdiv unit (ctrl pulse in, resultRDY pulse out).

Parameters:
- WIDTH, 32, data width; fixed at 32 for this processor.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ctrl_shift  input  1  start pulse; sampled on rising edge
- data_operand  input  WIDTH  value to shift; sampled with ctrl_shift
- shamt  input  SHW  shift amount; sampled with ctrl_shift
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (ROR only with the optional feature)
- data_result  output  WIDTH  shifted value; valid when data_resultRDY=1, held until next accepted start
- data_resultRDY  output  1  one-cycle pulse: result valid
- busy  output  1  high while an operation is in progress

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, data_result=0, data_resultRDY=0, busy=0, internal counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: ctrl_shift=1 at an edge loads work_reg<=data_operand, latches shamt and op, sets cnt<=0 and moves to RUN. Otherwise stays in IDLE.
- RUN, each edge:
  - If latched shamt[cnt]=1, work_reg<=work_reg shifted by 2^cnt per op; otherwise work_reg is unchanged.
  - cnt<=cnt+1.
  - When cnt==SHW-1 is processed, move to DONE.
- Shift fill rules:
  - SLL fills zeros at the LSB end.
  - SRL fills zeros at the MSB end.
  - SRA replicates the latched operand sign (bit 31 of work_reg, which is invariant under SRA).
- DONE: data_resultRDY=1 for exactly this one cycle. Next edge goes to IDLE, or to RUN if ctrl_shift=1, which is a back-to-back accept.
- Latency: start sampled at edge E; RUN covers edges E+1..E+5; data_resultRDY is high in the cycle after edge E+5. This is fixed regardless of shamt, including shamt=0.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- data_result=work_reg. It holds its value in IDLE after DONE until the next accepted start.
- ctrl_shift while in RUN: ignored. No queueing; the in-flight operation and its latched shamt/op/operand are unaffected.
- Input changes after the start edge have no effect, since all operands are latched.
- Reset asserted mid-RUN or in DONE: on that edge, return to reset values; no data_resultRDY pulse is produced.
- op=11 without the optional feature: treated as SLL.
- Boundary: shamt=31 with SRA of a negative value gives all ones; shamt=31 with SLL of 1 gives 0x80000000.

Optional Feature:
- Macro: SEQ_SHIFT_ROTATE_EN.
- Defined: op=11 performs rotate right; bits shifted out of the LSB re-enter at the MSB at each sub-shift stage.
- Undefined: op=11 aliases SLL and no rotate logic is synthesised.

Test Plan:
- Reset, then idle 3 cycles -> data_result=0x00000000, data_resultRDY=0, busy=0 throughout.
- SLL with operand=0x00000001, shamt=31 -> RDY pulses exactly 6 cycles after start; result=0x80000000; busy high for 6 cycles.
- SRA with operand=0x80000000, shamt=4 -> 0xF8000000. SRL with the same inputs -> 0x08000000. SRA with shamt=0 on 0x80000000 -> 0x80000000, still with 6-cycle latency.
- Start SLL 0x0000FFFF, shamt=8; pulse ctrl_shift again at cycle 2 with different inputs -> second start ignored; result=0x00FFFF00. Then assert ctrl_shift during the DONE cycle with SRL 0xF0000000, shamt=28 -> back-to-back accept; next RDY gives 0x0000000F.
- Start SRA 0xFFFF0000, shamt=16; assert reset at cycle 3 -> no RDY pulse; outputs return to 0. A fresh start afterward completes normally.
- With SEQ_SHIFT_ROTATE_EN: op=11, operand=0x00000003, shamt=1 -> 0x80000001. Without the macro, the same stimulus -> 0x00000006.

Source files
------------

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle logarithmic shifter (SLL/SRL/SRA), one power-of-two sub-shift per cycle.
// Optional rotate-right on op=11 when SEQ_SHIFT_ROTATE_EN is defined; otherwise op=11 behaves as SLL.
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_shift,
    input  logic [WIDTH-1:0] data_operand,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(SHW);
    localparam logic [CW-1:0] LAST = CW'(SHW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work_reg;
    logic [SHW-1:0]   shamt_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [SHW:0]     amt;
    logic [WIDTH-1:0] sh_sll;
    logic [WIDTH-1:0] sh_srl;
    logic [WIDTH-1:0] sh_sra;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stepped;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic [WIDTH-1:0] sh_ror;
`endif

    assign data_result = work_reg;

    // One sub-shift by 2^cnt, applied only when the matching shamt bit is set
    always_comb begin
        amt     = (SHW + 1)'(1) << cnt;
        sh_sll  = work_reg << amt;
        sh_srl  = work_reg >> amt;
        sh_sra  = $signed(work_reg) >>> amt;
`ifdef SEQ_SHIFT_ROTATE_EN
        sh_ror  = (work_reg >> amt) | (work_reg << (WIDTH - int'(amt)));
        shifted = op_q == 2'b01 ? sh_srl : op_q == 2'b10 ? sh_sra : op_q == 2'b11 ? sh_ror : sh_sll;
`else
        shifted = op_q == 2'b01 ? sh_srl : op_q == 2'b10 ? sh_sra : sh_sll;
`endif
        stepped = shamt_q[cnt] ? shifted : work_reg;
    end

    // Control FSM: accept in IDLE or DONE (back-to-back), step through every shamt bit in RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            work_reg       <= '0;
            shamt_q        <= '0;
            op_q           <= '0;
            cnt            <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_shift) begin
                        work_reg <= data_operand;
                        shamt_q  <= shamt;
                        op_q     <= op;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work_reg <= stepped;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: randomized and directed checks of seq_shift_unit against a transaction-level model.
module tb_seq_shift_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_shift = 1'b0;
    logic [31:0] data_operand = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  op = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int tests = 0;
    int fails = 0;

    seq_shift_unit dut (
        .clock(clock), .reset(reset), .ctrl_shift(ctrl_shift), .data_operand(data_operand),
        .shamt(shamt), .op(op), .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            2'b01: return a >> s;
            2'b10: return sa >>> s;
`ifdef SEQ_SHIFT_ROTATE_EN
            2'b11: return (a >> s) | (a << (32 - int'(s)));
`endif
            default: return a << s;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: a start is accepted unless one is in flight; result appears 6 cycles later
    int          edge_n = 0;
    int          start_edge = -1;
    logic [31:0] exp_res = '0;
    logic        exp_busy = 1'b0;
    logic        exp_rdy = 1'b0;
    logic        armed = 1'b0;

    always @(posedge clock) begin
        edge_n++;
        if (reset) begin
            start_edge = -1;
            exp_res    = '0;
            armed      = 1'b1;
        end else if (ctrl_shift && (start_edge < 0 || edge_n - start_edge >= 6)) begin
            start_edge = edge_n;
            exp_res    = ref_shift(op, data_operand, shamt);
        end
        exp_busy = start_edge >= 0 && edge_n - start_edge <= 5;
        exp_rdy  = start_edge >= 0 && edge_n - start_edge == 5;
    end

    always @(posedge clock) begin
        #1;
        if (armed) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("rdy", 32'(data_resultRDY), 32'(exp_rdy));
            if (!exp_busy || exp_rdy) check("result", data_result, exp_res);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        ctrl_shift = 1'b1; op = o; data_operand = a; shamt = s;
        tick();
        ctrl_shift = 1'b0; op = 2'($urandom); data_operand = $urandom; shamt = 5'($urandom);
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            if (data_resultRDY) lat = k;
            else tick();
        end
    endtask

    task automatic directed(input string nm, input logic [1:0] o, input logic [31:0] a,
                            input logic [4:0] s, input logic [31:0] exp);
        int lat;
        start(o, a, s);
        wait_rdy(lat);
        check({nm, "_latency"}, 32'(lat), 32'd6);
        check(nm, data_result, exp);
    endtask

    initial begin
        int lat;
        check("pin_sll31", ref_shift(2'b00, 32'h1, 5'd31), 32'h8000_0000);
        check("pin_sra4", ref_shift(2'b10, 32'h8000_0000, 5'd4), 32'hF800_0000);
        check("pin_sra31", ref_shift(2'b10, 32'h8765_4321, 5'd31), 32'hFFFF_FFFF);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_result", data_result, 32'h0);
            check("idle_rdy", 32'(data_resultRDY), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
        end
        directed("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        tick();
        directed("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
        directed("srl4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000);
        directed("sra0", 2'b10, 32'h8000_0000, 5'd0, 32'h8000_0000);
        directed("sra31", 2'b10, 32'hC000_0001, 5'd31, 32'hFFFF_FFFF);
        tick();
        start(2'b00, 32'h0000_FFFF, 5'd8);
        ctrl_shift = 1'b1; op = 2'b01; data_operand = 32'h1234_5678; shamt = 5'd3;
        tick();
        ctrl_shift = 1'b0;
        wait_rdy(lat);
        check("ignore_latency", 32'(lat), 32'd5);
        check("ignore_result", data_result, 32'h00FF_FF00);
        directed("b2b", 2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F);
        tick();
        start(2'b10, 32'hFFFF_0000, 5'd16);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_result", data_result, 32'h0);
        wait_rdy(lat);
        check("rst_no_rdy", 32'(lat), 32'hFFFF_FFFF);
`ifdef SEQ_SHIFT_ROTATE_EN
        directed("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h8000_0001);
`else
        directed("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h0000_0006);
`endif
        for (int i = 0; i < 600; i++) begin
            ctrl_shift   = ($urandom % 4) == 0;
            op           = 2'($urandom);
            data_operand = $urandom;
            shamt        = 5'($urandom);
            reset        = ($urandom % 113) == 0;
            tick();
        end
        ctrl_shift = 1'b0; reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
